inst_deco_pipe: RTL and testbench

Registered, parametrised instruction decode stage for the Vicharak CPU pipeline, between fetch and register-read/execute.
- Accepts raw instruction words over a valid/ready handshake.
- Classifies each word as R-format, I-format or illegal, extracts register fields and produces an extended immediate and register-file enables.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Supports a synchronous pipeline flush.

---
 rtl/deco_pkg.sv | 28 ++
 rtl/inst_field_decode.sv | 74 +++++++
 rtl/inst_deco_pipe.sv | 136 +++++++++++++
 tb/tb_inst_deco_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deco_pkg.sv
// Shared types and field-position helpers for the instruction decode stage.
package deco_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_ILL = 2'd2
    } fmt_e;

    localparam int DEF_OPW  = 5;
    localparam int DEF_RAW  = 4;
    localparam int DEF_IW   = 19;
    localparam int DEF_XLEN = 16;

    // Register fields are packed directly below the opcode, rs1 first.
    function automatic int rs1_msb(input int iw, input int opw);
        return iw - opw - 1;
    endfunction

    function automatic int rs2_msb(input int iw, input int opw, input int raw);
        return iw - opw - raw - 1;
    endfunction

    function automatic int rd_msb(input int iw, input int opw, input int raw);
        return iw - opw - 2 * raw - 1;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational decode of one raw instruction word into its register fields,
// extended immediate and register-file enables.
module inst_field_decode
    import deco_pkg::*;
#(
    parameter int OPW       = DEF_OPW,
    parameter int RAW       = DEF_RAW,
    parameter int IW        = DEF_IW,
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_R_OPS = 16,
    parameter int NUM_I_OPS = 8,
    parameter bit SEXT_IMM  = 1'b1
) (
    input  logic [IW-1:0]   instr,
    output logic [OPW-1:0]  opcode,
    output fmt_e            fmt,
    output logic [RAW-1:0]  rs1,
    output logic [RAW-1:0]  rs2,
    output logic [RAW-1:0]  rd,
    output logic [XLEN-1:0] imm,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic            rd_we,
    output logic            illegal
);

    localparam int IMMW    = IW - OPW - RAW;
    localparam int RS1_MSB = rs1_msb(IW, OPW);
    localparam int RS2_MSB = rs2_msb(IW, OPW, RAW);
    localparam int RD_MSB  = rd_msb(IW, OPW, RAW);

    logic [RAW-1:0]  f_rs1, f_rs2, f_rd;
    logic [IMMW-1:0] raw_imm;
    logic [XLEN-1:0] ext_imm;

    assign opcode  = instr[IW-1 -: OPW];
    assign f_rs1   = instr[RS1_MSB -: RAW];
    assign f_rs2   = instr[RS2_MSB -: RAW];
    assign f_rd    = instr[RD_MSB -: RAW];
    assign raw_imm = instr[IMMW-1:0];
    assign ext_imm = SEXT_IMM ? XLEN'($signed(raw_imm)) : XLEN'(raw_imm);

    always_comb begin
        fmt     = FMT_ILL;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        imm     = '0;
        rs1_en  = 1'b0;
        rs2_en  = 1'b0;
        rd_we   = 1'b0;
        illegal = 1'b1;
        if (int'(opcode) < NUM_R_OPS) begin
            fmt     = FMT_R;
            rs1     = f_rs1;
            rs2     = f_rs2;
            rd      = f_rd;
            rs1_en  = 1'b1;
            rs2_en  = 1'b1;
            rd_we   = 1'b1;
            illegal = 1'b0;
        end else if (int'(opcode) < NUM_R_OPS + NUM_I_OPS) begin
            // I-format reads and writes the same register.
            fmt     = FMT_I;
            rs1     = f_rs1;
            rd      = f_rs1;
            imm     = ext_imm;
            rs1_en  = 1'b1;
            rd_we   = 1'b1;
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/inst_deco_pipe.sv
// Registered decode stage: decodes on entry, then a main register plus a skid
// register give full throughput behind a registered in_ready.
module inst_deco_pipe
    import deco_pkg::*;
#(
    parameter int OPW       = DEF_OPW,
    parameter int RAW       = DEF_RAW,
    parameter int IW        = DEF_IW,
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_R_OPS = 16,
    parameter int NUM_I_OPS = 8,
    parameter bit SEXT_IMM  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_opcode,
    output logic [1:0]      out_fmt,
    output logic [RAW-1:0]  out_rs1,
    output logic [RAW-1:0]  out_rs2,
    output logic [RAW-1:0]  out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic            out_illegal
);

    typedef struct packed {
        logic [OPW-1:0]  opcode;
        fmt_e            fmt;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] imm;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_MAIN,
        ST_FULL
    } state_e;

    bundle_t dec, main_q, skid_q;
    state_e  state;
    logic    accept;

    inst_field_decode #(
        .OPW       (OPW),
        .RAW       (RAW),
        .IW        (IW),
        .XLEN      (XLEN),
        .NUM_R_OPS (NUM_R_OPS),
        .NUM_I_OPS (NUM_I_OPS),
        .SEXT_IMM  (SEXT_IMM)
    ) u_decode (
        .instr   (in_instr),
        .opcode  (dec.opcode),
        .fmt     (dec.fmt),
        .rs1     (dec.rs1),
        .rs2     (dec.rs2),
        .rd      (dec.rd),
        .imm     (dec.imm),
        .rs1_en  (dec.rs1_en),
        .rs2_en  (dec.rs2_en),
        .rd_we   (dec.rd_we),
        .illegal (dec.illegal)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q    <= dec;
                        out_valid <= 1'b1;
                        state     <= ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (accept && out_ready) begin
                        main_q <= dec;
                    end else if (accept) begin
                        skid_q   <= dec;
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_MAIN;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign out_opcode  = main_q.opcode;
    assign out_fmt     = main_q.fmt;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_imm     = main_q.imm;
    assign out_rs1_en  = main_q.rs1_en;
    assign out_rs2_en  = main_q.rs2_en;
    assign out_rd_we   = main_q.rd_we;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_inst_deco_pipe.sv
// Self-checking bench for inst_deco_pipe: directed cases plus randomized traffic
// checked against an in-order queue of arithmetically decoded words.
module tb_inst_deco_pipe;

    typedef struct packed {
        logic [4:0]  op;
        logic [1:0]  fmt;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [15:0] imm;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic        ill;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [18:0] in_instr = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [4:0]  out_opcode;
    logic [1:0]  out_fmt;
    logic [3:0]  out_rs1, out_rs2, out_rd;
    logic [15:0] out_imm;
    logic        out_rs1_en, out_rs2_en, out_rd_we, out_illegal;

    logic        z_in_ready, z_out_valid;
    logic [4:0]  z_opcode;
    logic [1:0]  z_fmt;
    logic [3:0]  z_rs1, z_rs2, z_rd;
    logic [15:0] z_imm;
    logic        z_rs1_en, z_rs2_en, z_rd_we, z_illegal;

    bun_t got;
    bun_t expq[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    inst_deco_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_fmt(out_fmt),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    inst_deco_pipe #(.SEXT_IMM(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_instr(in_instr),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .out_opcode(z_opcode), .out_fmt(z_fmt),
        .out_rs1(z_rs1), .out_rs2(z_rs2), .out_rd(z_rd),
        .out_imm(z_imm), .out_rs1_en(z_rs1_en), .out_rs2_en(z_rs2_en),
        .out_rd_we(z_rd_we), .out_illegal(z_illegal)
    );

    assign got = '{out_opcode, out_fmt, out_rs1, out_rs2, out_rd, out_imm,
                   out_rs1_en, out_rs2_en, out_rd_we, out_illegal};

    function automatic bun_t ref_decode(input logic [18:0] w);
        bun_t b;
        int unsigned v, op, iv;
        v  = w;
        op = v / 16384;
        b  = '0;
        b.op = 5'(op);
        if (op < 16) begin
            b.fmt = 2'd0;
            b.rs1 = 4'((v / 1024) % 16);
            b.rs2 = 4'((v / 64) % 16);
            b.rd  = 4'((v / 4) % 16);
            b.rs1_en = 1'b1; b.rs2_en = 1'b1; b.rd_we = 1'b1;
        end else if (op < 24) begin
            b.fmt = 2'd1;
            b.rs1 = 4'((v / 1024) % 16);
            b.rd  = b.rs1;
            iv = v % 1024;
            b.imm = (iv >= 512) ? 16'(iv + 65536 - 1024) : 16'(iv);
            b.rs1_en = 1'b1; b.rd_we = 1'b1;
        end else begin
            b.fmt = 2'd2;
            b.ill = 1'b1;
        end
        return b;
    endfunction

    // One clock: present inputs, advance the occupancy/order model, settle #1 after the edge.
    task automatic tick(input bit v, input logic [18:0] w, input bit r,
                        input bit f = 1'b0, input bit rn = 1'b1);
        bit acc, pop;
        in_valid = v; in_instr = w; out_ready = r; flush = f; rst_n = rn;
        acc = v && (expq.size() < 2);
        pop = r && (expq.size() > 0);
        @(posedge clk); #1;
        if (!rn || f) expq.delete();
        else begin
            if (pop) void'(expq.pop_front());
            if (acc) expq.push_back(ref_decode(w));
        end
        flush = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick(1'b1, 19'h0D670, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b got=%h required valid=0 data=0", out_valid, got);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got=%b required=1", in_ready);
        end
    endtask

    task automatic test_r_format();
        bun_t e;
        e = '{5'd3, 2'd0, 4'd5, 4'd9, 4'd12, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tick(1'b1, 19'h0D670, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            failures++;
            $display("FAIL r_format: valid=%b got=%h required valid=1 data=%h", out_valid, got, e);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL r_drain: valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_i_format();
        bun_t e;
        e = '{5'd17, 2'd1, 4'd7, 4'd0, 4'd7, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tick(1'b1, 19'h45FFF, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            failures++;
            $display("FAIL i_sext: valid=%b got=%h required valid=1 data=%h", out_valid, got, e);
        end
        checks++;
        if (z_out_valid !== 1'b1 || z_imm !== 16'h03FF || z_rd !== 4'd7) begin
            failures++;
            $display("FAIL i_zext: valid=%b imm=%h rd=%0d required valid=1 imm=03ff rd=7",
                     z_out_valid, z_imm, z_rd);
        end
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_illegal();
        bun_t e;
        e = '{5'd28, 2'd2, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tick(1'b1, 19'h70000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            failures++;
            $display("FAIL illegal: valid=%b got=%h required valid=1 data=%h", out_valid, got, e);
        end
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [18:0] a, b, c;
        bit          vs[7], rs[7];
        a = 19'h0D670; b = 19'h45FFF; c = 19'h23456;
        vs = '{1, 1, 1, 1, 1, 0, 0};
        rs = '{0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            tick(vs[i], (i == 0) ? a : (i == 1) ? b : c, rs[i]);
            checks++;
            if (out_valid !== (expq.size() > 0) || in_ready !== (expq.size() < 2)) begin
                failures++;
                $display("FAIL bp_ctrl[%0d]: valid=%b ready=%b required valid=%b ready=%b",
                         i, out_valid, in_ready, expq.size() > 0, expq.size() < 2);
            end
            if (expq.size() > 0) begin
                checks++;
                if (got !== expq[0]) begin
                    failures++;
                    $display("FAIL bp_data[%0d]: got=%h required=%h", i, got, expq[0]);
                end
            end
        end
        // Sustained streaming: every cycle must present the word accepted one cycle earlier.
        for (int i = 0; i < 20; i++) begin
            logic [18:0] w;
            w = 19'($urandom);
            tick(1'b1, w, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || got !== ref_decode(w)) begin
                failures++;
                $display("FAIL b2b[%0d]: valid=%b ready=%b got=%h required 1 1 %h",
                         i, out_valid, in_ready, got, ref_decode(w));
            end
        end
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_flush();
        tick(1'b1, 19'h11111, 1'b0);
        tick(1'b1, 19'h22222, 1'b0);
        tick(1'b1, 19'h0D670, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
        end
        tick(1'b1, 19'h45FFF, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_decode(19'h45FFF)) begin
            failures++;
            $display("FAIL flush_resume: valid=%b got=%h required valid=1 data=%h",
                     out_valid, got, ref_decode(19'h45FFF));
        end
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 19'h33333, 1'b0);
        tick(1'b1, 19'h44444, 1'b0);
        tick(1'b1, 19'h0D670, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b ready=%b got=%h required 0 1 0", out_valid, in_ready, got);
        end
        tick(1'b1, 19'h0D670, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_decode(19'h0D670)) begin
            failures++;
            $display("FAIL reset_resume: valid=%b got=%h required valid=1 data=%h",
                     out_valid, got, ref_decode(19'h0D670));
        end
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 39) == 0);
            tick(v, 19'($urandom), r, f);
            checks++;
            if (out_valid !== (expq.size() > 0) || in_ready !== (expq.size() < 2)) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b required valid=%b ready=%b",
                         i, out_valid, in_ready, expq.size() > 0, expq.size() < 2);
            end
            if (expq.size() > 0) begin
                checks++;
                if (got !== expq[0]) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: got=%h required=%h", i, got, expq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_format();
        test_i_format();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
